// File: rtl/urisc_ctrl_if.sv
// urisc_ctrl_if - RAM bus between the SUBLEQ core (master) and the 128x8 RAM (slave).
// RDATA is combinational from ADDRESS on the slave side.
interface urisc_ctrl_if;
   logic       CS;
   logic       READ;
   logic       WRITE;
   logic [7:0] ADDRESS;
   logic [7:0] WDATA;
   logic [7:0] RDATA;

   modport master (output CS, READ, WRITE, ADDRESS, WDATA, input RDATA);
   modport slave  (input CS, READ, WRITE, ADDRESS, WDATA, output RDATA);
endinterface

// File: rtl/urisc_ctrl.sv
// urisc_ctrl - SUBLEQ core: mem[B] <= mem[B] - mem[A]; branch to C if result <= 0.
// Sole master of the unified 128x8 instruction/data RAM.
// Six single-cycle states per instruction: FA FB FC RA RB WB.
// Optional macro URISC_ICOUNT_EN adds a saturating 16-bit retired-instruction
// counter on output icount.
module urisc_ctrl #(
   parameter logic [7:0] RESET_PC  = 8'd1,
   parameter logic [7:0] HALT_ADDR = 8'd0,
   parameter int         MEM_DEPTH = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   urisc_ctrl_if.master  bus,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    pc_o
`ifdef URISC_ICOUNT_EN
   ,
   output logic [15:0]   icount
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB, S_HALT
   } state_t;

   state_t     r_state;
   logic [7:0] r_pc, r_a, r_b, r_c, r_opa, r_opb;
   logic       r_err;
`ifdef URISC_ICOUNT_EN
   logic [15:0] r_icount;
`endif

   logic       w_fa_halt, w_fa_err, w_ra_err, w_take;
   logic [7:0] w_r;
   logic       w_cs, w_rd, w_wr;
   logic [7:0] w_addr, w_wdata;

   // A fetch must fit all three instruction bytes inside the RAM.
   assign w_fa_halt = (r_pc == HALT_ADDR);
   assign w_fa_err  = (int'(r_pc) > MEM_DEPTH - 3);
   assign w_ra_err  = (int'(r_a) >= MEM_DEPTH) || (int'(r_b) >= MEM_DEPTH);
   assign w_r       = r_opb - r_opa;
   assign w_take    = w_r[7] || (w_r == 8'h00);

   // Bus is a pure decode of state and registers, so reset idles it at once.
   always_comb begin
      w_cs    = 1'b0;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_addr  = 8'h00;
      w_wdata = 8'h00;
      case (r_state)
         S_FA: if (!w_fa_halt && !w_fa_err) begin
            w_cs = 1'b1; w_rd = 1'b1; w_addr = r_pc;
         end
         S_FB: begin w_cs = 1'b1; w_rd = 1'b1; w_addr = r_pc + 8'd1; end
         S_FC: begin w_cs = 1'b1; w_rd = 1'b1; w_addr = r_pc + 8'd2; end
         S_RA: if (!w_ra_err) begin
            w_cs = 1'b1; w_rd = 1'b1; w_addr = r_a;
         end
         S_RB: begin w_cs = 1'b1; w_rd = 1'b1; w_addr = r_b; end
         S_WB: begin w_cs = 1'b1; w_wr = 1'b1; w_addr = r_b; w_wdata = w_r; end
         default: ;
      endcase
   end

   assign bus.CS      = w_cs;
   assign bus.READ    = w_rd;
   assign bus.WRITE   = w_wr;
   assign bus.ADDRESS = w_addr;
   assign bus.WDATA   = w_wdata;

   assign busy = (r_state != S_IDLE) && (r_state != S_HALT);
   assign done = (r_state == S_HALT);
   assign err  = r_err;
   assign pc_o = r_pc;
`ifdef URISC_ICOUNT_EN
   assign icount = r_icount;
`endif

   // Main sequencer: one state per bus cycle, RDATA captured at end of each read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_a     <= 8'h00;
         r_b     <= 8'h00;
         r_c     <= 8'h00;
         r_opa   <= 8'h00;
         r_opb   <= 8'h00;
         r_err   <= 1'b0;
`ifdef URISC_ICOUNT_EN
         r_icount <= 16'h0000;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_HALT: if (start) begin
               r_pc    <= RESET_PC;
               r_err   <= 1'b0;
`ifdef URISC_ICOUNT_EN
               r_icount <= 16'h0000;
`endif
               r_state <= S_FA;
            end
            S_FA: begin
               if (w_fa_halt) begin
                  r_state <= S_HALT;
               end else if (w_fa_err) begin
                  r_err   <= 1'b1;
                  r_state <= S_HALT;
               end else begin
                  r_a     <= bus.RDATA;
                  r_state <= S_FB;
               end
            end
            S_FB: begin
               r_b     <= bus.RDATA;
               r_state <= S_FC;
            end
            S_FC: begin
               r_c     <= bus.RDATA;
               r_state <= S_RA;
            end
            S_RA: begin
               if (w_ra_err) begin
                  r_err   <= 1'b1;
                  r_state <= S_HALT;
               end else begin
                  r_opa   <= bus.RDATA;
                  r_state <= S_RB;
               end
            end
            S_RB: begin
               r_opb   <= bus.RDATA;
               r_state <= S_WB;
            end
            S_WB: begin
               r_pc    <= w_take ? r_c : (r_pc + 8'd3);
`ifdef URISC_ICOUNT_EN
               if (r_icount != 16'hFFFF) r_icount <= r_icount + 16'd1;
`endif
               r_state <= S_FA;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_urisc_ctrl.sv
// tb_urisc_ctrl - directed SUBLEQ programs against a behavioural 128x8 RAM.
module tb_urisc_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, err;
   logic [7:0] pc_o;
`ifdef URISC_ICOUNT_EN
   logic [15:0] icount;
`endif

   urisc_ctrl_if bus ();

   urisc_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .pc_o  (pc_o)
`ifdef URISC_ICOUNT_EN
      ,
      .icount(icount)
`endif
   );

   always #5 clk = ~clk;

   // RAM model; loads go through the same process as bus writes
   logic [7:0] mem [0:127];
   logic       ld_clr = 1'b0, ld_en = 1'b0;
   logic [6:0] ld_a = 7'd0;
   logic [7:0] ld_d = 8'd0;
   logic       bad = 1'b0;

   always @(posedge clk) begin
      if (ld_clr) for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      else if (ld_en) mem[ld_a] <= ld_d;
      else if (bus.CS && bus.WRITE && bus.ADDRESS < 8'd128) mem[bus.ADDRESS[6:0]] <= bus.WDATA;
   end

   assign bus.RDATA = (bus.ADDRESS < 8'd128) ? mem[bus.ADDRESS[6:0]] : 8'h00;

   always @(posedge clk) if (bus.CS && bus.ADDRESS >= 8'd128) bad <= 1'b1;

   int n_vec = 0, n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      ld_clr = 1'b1; tick(); ld_clr = 1'b0;
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      ld_en = 1'b1; ld_a = 7'(a); ld_d = d; tick(); ld_en = 1'b0;
   endtask

   task automatic load3(input int a, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      poke(a, x); poke(a + 1, y); poke(a + 2, z);
   endtask

   // start is sampled on the edge inside this task; returns in FA
   task automatic kick();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   // counts edges until done; optional stray start pulse; captures pc after 6 edges
   task automatic run(input int ghost, output int cyc, output logic [7:0] pc6);
      cyc = -1; pc6 = 8'hxx;
      for (int k = 1; k <= 400; k++) begin
         start = (k == ghost);
         tick();
         if (k == 6) pc6 = pc_o;
         if (done) begin cyc = k; break; end
      end
      start = 1'b0;
   endtask

   int         cyc;
   logic [7:0] pc6;

   initial begin
      // reset state
      tick(); tick();
      chk("rst_cs", bus.CS, 1'b0);
      chk("rst_rd", bus.READ, 1'b0);
      chk("rst_wr", bus.WRITE, 1'b0);
      chk("rst_addr", bus.ADDRESS, 8'h00);
      chk("rst_wdata", bus.WDATA, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_pc", pc_o, 8'd1);
      rst = 1'b0;
      clr();
      chk("idle_busy", busy, 1'b0);

      // no-branch program, with a stray start while busy
      load3(1, 8'd10, 8'd11, 8'd4);
      load3(4, 8'd12, 8'd12, 8'd0);
      poke(10, 8'd3); poke(11, 8'd5); poke(12, 8'd7);
      kick();
      chk("nb_busy", busy, 1'b1);
      chk("nb_fa_addr", bus.ADDRESS, 8'd1);
      chk("nb_fa_rd", {bus.CS, bus.READ, bus.WRITE}, 3'b110);
      run(3, cyc, pc6);
      chk("nb_cycles", cyc, 13);
      chk("nb_pc6", pc6, 8'd4);
      chk("nb_m11", mem[11], 8'd2);
      chk("nb_m12", mem[12], 8'd0);
      chk("nb_pc_end", pc_o, 8'd0);
      chk("nb_busy_end", busy, 1'b0);
      chk("nb_err", err, 1'b0);
      chk("nb_bus_idle", bus.CS, 1'b0);
`ifdef URISC_ICOUNT_EN
      chk("nb_icount", icount, 16'd2);
`endif

      // restart from HALT: negative result branches to 20
      clr();
      load3(1, 8'd10, 8'd11, 8'd20);
      load3(20, 8'd12, 8'd12, 8'd0);
      poke(10, 8'd5); poke(11, 8'd3); poke(12, 8'd9);
      kick();
      chk("rs_busy", busy, 1'b1);
      chk("rs_addr", bus.ADDRESS, 8'd1);
      chk("rs_done", done, 1'b0);
`ifdef URISC_ICOUNT_EN
      chk("rs_icount", icount, 16'd0);
`endif
      run(2, cyc, pc6);
      chk("ng_pc6", pc6, 8'd20);
      chk("ng_m11", mem[11], 8'hFE);
      chk("ng_m12", mem[12], 8'h00);
      chk("ng_cycles", cyc, 13);
      chk("ng_err", err, 1'b0);

      // operand address out of range: no access, err after RA
      clr();
      load3(1, 8'd200, 8'd11, 8'd4);
      poke(11, 8'd5);
      kick();
      run(0, cyc, pc6);
      chk("re_cycles", cyc, 4);
      chk("re_err", err, 1'b1);
      chk("re_done", done, 1'b1);
      chk("re_noacc", bad, 1'b0);
      chk("re_m11", mem[11], 8'd5);

      // branch target at last legal fetch (125) runs; start clears err
      load3(1, 8'd10, 8'd10, 8'd125);
      load3(125, 8'd10, 8'd10, 8'd0);
      kick();
      chk("ok_errclr", err, 1'b0);
      run(0, cyc, pc6);
      chk("ok_pc6", pc6, 8'd125);
      chk("ok_cycles", cyc, 13);
      chk("ok_err", err, 1'b0);

      // branch target 126 cannot hold a full instruction
      load3(1, 8'd10, 8'd10, 8'd126);
      kick();
      run(0, cyc, pc6);
      chk("pe_cycles", cyc, 7);
      chk("pe_err", err, 1'b1);
      chk("pe_pc", pc_o, 8'd126);
      chk("pe_noacc", bad, 1'b0);

      // reset during WB: write withdrawn in the same cycle
      clr();
      load3(1, 8'd10, 8'd11, 8'd4);
      poke(10, 8'd3); poke(11, 8'd5);
      kick();
      for (int k = 1; k <= 5; k++) tick();
      chk("mr_wb_wr", bus.WRITE, 1'b1);
      rst = 1'b1; #1;
      chk("mr_wr", bus.WRITE, 1'b0);
      chk("mr_cs", bus.CS, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_pc", pc_o, 8'd1);
      tick();
      chk("mr_m11", mem[11], 8'd5);
      rst = 1'b0;
      tick();
      chk("mr_idle", {busy, done}, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
